// File: rtl/design_select_sequencer.sv
// design_select_sequencer
//
// Purpose:
//   Arbitrates which student design inside integrated_designs owns the shared
//   clock, reset and 34-bit GPIO bank. The raw select pads are synchronized
//   and debounced. An accepted change then runs a fixed hand-over:
//     1. QUIESCE: the old design is disabled and held in reset, GPIOs are
//        forced to inputs.
//     2. HOLD: the new design is enabled and clocked while still in reset.
//     3. RUN: reset is released and the GPIOs are handed back.
//
// Ports:
//   clk              system clock (wb_clk_i)
//   n_rst            asynchronous active-low reset
//   design_select_in raw select code from the pads, asynchronous to clk
//   active_select    select code currently granted
//   design_en        one-hot enable of the granted design (bit 0 never set)
//   design_n_rst     active-low reset to the design array
//   gpio_oeb_force   1 = wrapper forces every gpio_oeb high (input mode)
//   busy             high while QUIESCE or HOLD is in progress
//   switch_count     completed switches, saturating at 255
//
// All outputs are registered. Their next values are derived from the next
// state and the next active_select, so they change on the same edge as the
// state.
module design_select_sequencer #(
  parameter int SEL_W         = 4,
  parameter int NUM_DESIGNS   = 16,
  parameter int STABLE_CYCLES = 4,
  parameter int GUARD_CYCLES  = 8
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic [SEL_W-1:0]       design_select_in,
  output logic [SEL_W-1:0]       active_select,
  output logic [NUM_DESIGNS-1:0] design_en,
  output logic                   design_n_rst,
  output logic                   gpio_oeb_force,
  output logic                   busy,
  output logic [7:0]             switch_count
);

  localparam int STAB_W  = $clog2(STABLE_CYCLES + 1);
  localparam int GUARD_W = $clog2(GUARD_CYCLES + 1);

  localparam logic [STAB_W-1:0]      STAB_DONE  = STAB_W'(STABLE_CYCLES);
  localparam logic [GUARD_W-1:0]     GUARD_LAST = GUARD_W'(GUARD_CYCLES - 1);
  localparam logic [NUM_DESIGNS-1:0] EN_ONE     = {{(NUM_DESIGNS-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_QUIESCE = 2'd1,
    ST_HOLD    = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [SEL_W-1:0]       sel_meta_q;
  logic [SEL_W-1:0]       sel_sync_q;
  logic [SEL_W-1:0]       cand_q, cand_d;
  logic [STAB_W-1:0]      stab_q, stab_d;
  logic [GUARD_W-1:0]     guard_q, guard_d;
  logic [SEL_W-1:0]       active_q, active_d;
  logic [NUM_DESIGNS-1:0] design_en_q, design_en_d;
  logic                   design_n_rst_q, design_n_rst_d;
  logic                   oeb_force_q, oeb_force_d;
  logic                   busy_q, busy_d;
  logic [7:0]             switch_count_q, switch_count_d;

  always_comb begin
    state_d        = state_q;
    cand_d         = cand_q;
    stab_d         = stab_q;
    guard_d        = guard_q;
    active_d       = active_q;
    switch_count_d = switch_count_q;

    case (state_q)
      ST_RUN: begin
        // The filter only runs in RUN. Once the window is full we leave on
        // this edge whatever the synchronized value is doing now.
        if (stab_q == STAB_DONE) begin
          state_d = ST_QUIESCE;
          stab_d  = '0;
          guard_d = '0;
        end else if (sel_sync_q != active_q) begin
          if (sel_sync_q == cand_q) begin
            stab_d = stab_q + STAB_W'(1);
          end else begin
            cand_d = sel_sync_q;
            stab_d = STAB_W'(1);
          end
        end else begin
          stab_d = '0;
        end
      end
      ST_QUIESCE: begin
        if (guard_q == GUARD_LAST) begin
          state_d  = ST_HOLD;
          active_d = cand_q;
          guard_d  = '0;
        end else begin
          guard_d = guard_q + GUARD_W'(1);
        end
      end
      ST_HOLD: begin
        if (guard_q == GUARD_LAST) begin
          state_d = ST_RUN;
          // Any select still pending must earn a fresh stability window.
          stab_d  = '0;
          guard_d = '0;
          if (switch_count_q != 8'hff) switch_count_d = switch_count_q + 8'd1;
        end else begin
          guard_d = guard_q + GUARD_W'(1);
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase

    // Code 0 means no design: it never gets an enable, a reset release or
    // the GPIOs.
    design_en_d    = '0;
    design_n_rst_d = 1'b0;
    oeb_force_d    = 1'b1;
    busy_d         = (state_d != ST_RUN);
    if (active_d != '0) begin
      if (state_d == ST_RUN || state_d == ST_HOLD) design_en_d = EN_ONE << active_d;
      if (state_d == ST_RUN) begin
        design_n_rst_d = 1'b1;
        oeb_force_d    = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q        <= ST_RUN;
      sel_meta_q     <= '0;
      sel_sync_q     <= '0;
      cand_q         <= '0;
      stab_q         <= '0;
      guard_q        <= '0;
      active_q       <= '0;
      design_en_q    <= '0;
      design_n_rst_q <= 1'b0;
      oeb_force_q    <= 1'b1;
      busy_q         <= 1'b0;
      switch_count_q <= '0;
    end else begin
      sel_meta_q     <= design_select_in;
      sel_sync_q     <= sel_meta_q;
      state_q        <= state_d;
      cand_q         <= cand_d;
      stab_q         <= stab_d;
      guard_q        <= guard_d;
      active_q       <= active_d;
      design_en_q    <= design_en_d;
      design_n_rst_q <= design_n_rst_d;
      oeb_force_q    <= oeb_force_d;
      busy_q         <= busy_d;
      switch_count_q <= switch_count_d;
    end
  end

  assign active_select  = active_q;
  assign design_en      = design_en_q;
  assign design_n_rst   = design_n_rst_q;
  assign gpio_oeb_force = oeb_force_q;
  assign busy           = busy_q;
  assign switch_count   = switch_count_q;

endmodule

// File: tb/tb_design_select_sequencer.sv
// Directed testbench for design_select_sequencer (STABLE_CYCLES=4,
// GUARD_CYCLES=8). Inputs are driven and outputs sampled on the falling edge.
// "step(n)" advances over n rising edges. A select driven at a falling edge
// is first sampled by the next rising edge, E0. busy rises at E6. HOLD starts
// at E14. RUN returns at E22.
module tb_design_select_sequencer;

  logic        clk;
  logic        n_rst;
  logic [3:0]  design_select_in;
  logic [3:0]  active_select;
  logic [15:0] design_en;
  logic        design_n_rst;
  logic        gpio_oeb_force;
  logic        busy;
  logic [7:0]  switch_count;

  int n_assert = 0;
  int n_fail   = 0;

  design_select_sequencer #(
    .SEL_W(4), .NUM_DESIGNS(16), .STABLE_CYCLES(4), .GUARD_CYCLES(8)
  ) dut (
    .clk              (clk),
    .n_rst            (n_rst),
    .design_select_in (design_select_in),
    .active_select    (active_select),
    .design_en        (design_en),
    .design_n_rst     (design_n_rst),
    .gpio_oeb_force   (gpio_oeb_force),
    .busy             (busy),
    .switch_count     (switch_count)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] a, input logic [15:0] en,
                         input logic nr, input logic oeb, input logic b, input logic [7:0] cnt);
    chk({tag, ".active_select"},  32'(active_select),  32'(a));
    chk({tag, ".design_en"},      32'(design_en),      32'(en));
    chk({tag, ".design_n_rst"},   32'(design_n_rst),   32'(nr));
    chk({tag, ".gpio_oeb_force"}, 32'(gpio_oeb_force), 32'(oeb));
    chk({tag, ".busy"},           32'(busy),           32'(b));
    chk({tag, ".switch_count"},   32'(switch_count),   32'(cnt));
  endtask

  initial begin
    n_rst            = 1'b0;
    design_select_in = 4'd0;
    step(3);
    chk_all("reset_held", 4'd0, 16'h0000, 1'b0, 1'b1, 1'b0, 8'd0);
    n_rst = 1'b1;
    step(5);
    chk_all("idle_after_reset", 4'd0, 16'h0000, 1'b0, 1'b1, 1'b0, 8'd0);

    // Switch 0 -> 3: busy after 6 cycles, QUIESCE 8, HOLD 8, then RUN.
    design_select_in = 4'd3;
    step(6);
    chk_all("sel3_before_busy", 4'd0, 16'h0000, 1'b0, 1'b1, 1'b0, 8'd0);
    step(1);
    chk_all("sel3_quiesce_start", 4'd0, 16'h0000, 1'b0, 1'b1, 1'b1, 8'd0);
    step(7);
    chk_all("sel3_quiesce_end", 4'd0, 16'h0000, 1'b0, 1'b1, 1'b1, 8'd0);
    step(1);
    chk_all("sel3_hold_start", 4'd3, 16'h0008, 1'b0, 1'b1, 1'b1, 8'd0);
    step(7);
    chk_all("sel3_hold_end", 4'd3, 16'h0008, 1'b0, 1'b1, 1'b1, 8'd0);
    step(1);
    chk_all("sel3_run", 4'd3, 16'h0008, 1'b1, 1'b0, 1'b0, 8'd1);

    // 3-cycle glitch to 5 must not start a switch.
    design_select_in = 4'd5;
    step(3);
    design_select_in = 4'd3;
    for (int i = 0; i < 20; i++) begin
      step(1);
      chk("glitch_busy", 32'(busy), 32'd0);
    end
    chk_all("glitch_after", 4'd3, 16'h0008, 1'b1, 1'b0, 1'b0, 8'd1);

    // Switch to 7, change to 9 mid-QUIESCE: completes to 7 first.
    design_select_in = 4'd7;
    step(7);
    chk_all("sel7_quiesce", 4'd3, 16'h0000, 1'b0, 1'b1, 1'b1, 8'd1);
    step(2);
    design_select_in = 4'd9;
    step(6);
    chk_all("sel7_hold", 4'd7, 16'h0080, 1'b0, 1'b1, 1'b1, 8'd1);
    step(8);
    chk_all("sel7_run", 4'd7, 16'h0080, 1'b1, 1'b0, 1'b0, 8'd2);
    // Pending 9 needs a fresh 4-cycle window after RUN entry.
    step(4);
    chk("sel9_window_busy", 32'(busy), 32'd0);
    step(1);
    chk_all("sel9_quiesce", 4'd7, 16'h0000, 1'b0, 1'b1, 1'b1, 8'd2);
    step(16);
    chk_all("sel9_run", 4'd9, 16'h0200, 1'b1, 1'b0, 1'b0, 8'd3);

    // Switch to 0 runs the full sequence and ends idle.
    design_select_in = 4'd0;
    step(15);
    chk_all("sel0_hold", 4'd0, 16'h0000, 1'b0, 1'b1, 1'b1, 8'd3);
    step(8);
    chk_all("sel0_idle", 4'd0, 16'h0000, 1'b0, 1'b1, 1'b0, 8'd4);

    // Reset during HOLD of a switch to 4: immediate return to reset values.
    design_select_in = 4'd4;
    step(15);
    chk_all("sel4_hold", 4'd4, 16'h0010, 1'b0, 1'b1, 1'b1, 8'd4);
    #2 n_rst = 1'b0;
    #1 chk_all("abort_reset", 4'd0, 16'h0000, 1'b0, 1'b1, 1'b0, 8'd0);
    design_select_in = 4'd0;
    step(2);
    n_rst = 1'b1;
    step(30);
    chk_all("after_abort", 4'd0, 16'h0000, 1'b0, 1'b1, 1'b0, 8'd0);

    // 260 alternating switches between 1 and 2: count saturates at 255.
    for (int i = 0; i < 260; i++) begin
      design_select_in = (i % 2 == 0) ? 4'd1 : 4'd2;
      step(23);
      chk("sat_count", 32'(switch_count), (i + 1 > 255) ? 32'd255 : 32'(i + 1));
    end
    chk_all("sat_final", 4'd2, 16'h0004, 1'b1, 1'b0, 1'b0, 8'd255);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
